// File: rtl/accumulator_32bit_pkg.sv
// accumulator_32bit_pkg
//   Shared constants and helpers for the 32-bit registered CLA adder slice.
//   CLA_GROUP_W   : bit width of one carry-lookahead group
//   num_groups()  : number of lookahead groups for a given operand width
//   cla_gp_t      : group generate/propagate pair as seen by the lookahead unit
package accumulator_32bit_pkg;

  localparam int unsigned CLA_GROUP_W   = 4;
  localparam int unsigned DEFAULT_WIDTH = 32;

  function automatic int unsigned num_groups(input int unsigned width);
    return width / CLA_GROUP_W;
  endfunction

  localparam int unsigned DEFAULT_GROUPS = num_groups(DEFAULT_WIDTH);

  typedef struct packed {
    logic g;
    logic p;
  } cla_gp_t;

endpackage

// File: rtl/accumulator_32bit_cla_4bit.sv
// cla_4bit
//   One 4-bit carry-lookahead group. Produces the group sum from its local
//   carry-in, plus the group generate/propagate terms that the top-level
//   lookahead unit uses to form the carry into the next group.
//   Ports:
//     a, b    : group operand bits
//     cin     : carry into bit 0 of this group
//     s       : group sum bits
//     grp_g   : group generate  G = g3 | p3 g2 | p3 p2 g1 | p3 p2 p1 g0
//     grp_p   : group propagate P = p3 p2 p1 p0
module cla_4bit
  import accumulator_32bit_pkg::*;
(
  input  logic [CLA_GROUP_W-1:0] a,
  input  logic [CLA_GROUP_W-1:0] b,
  input  logic                   cin,
  output logic [CLA_GROUP_W-1:0] s,
  output logic                   grp_g,
  output logic                   grp_p
);

  logic [CLA_GROUP_W-1:0] g;
  logic [CLA_GROUP_W-1:0] p;
  logic [CLA_GROUP_W-1:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Internal carries are flattened sum-of-products, not a ripple chain.
  always_comb begin
    c    = '0;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & cin);
  end

  assign s = p ^ c;

  assign grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0]);
  assign grp_p = &p;

endmodule

// File: rtl/accumulator_32bit.sv
// accumulator_32bit
//   Registered WIDTH-bit adder: {o_c32, o_v} <= i_va + i_vb + i_c0.
//   Two-level carry lookahead: WIDTH/4 cla_4bit groups, with all group carries
//   formed directly from group G/P and i_c0.
//   Ports:
//     i_clk  : rising-edge clock
//     i_rst  : synchronous active-high reset, clears o_v and o_c32
//     i_va   : operand A
//     i_vb   : operand B
//     i_c0   : carry into bit 0
//     o_v    : registered sum
//     o_c32  : registered carry out of the MSB
module accumulator_32bit
  import accumulator_32bit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_va,
  input  logic [WIDTH-1:0] i_vb,
  input  logic             i_c0,
  output logic [WIDTH-1:0] o_v,
  output logic             o_c32
);

  localparam int unsigned NG = num_groups(WIDTH);

  cla_gp_t [NG-1:0] grp;
  logic    [NG:0]   grp_c;
  logic [WIDTH-1:0] sum;

  for (genvar k = 0; k < int'(NG); k++) begin : g_cla
    cla_4bit u_cla (
      .a     (i_va[k*CLA_GROUP_W +: CLA_GROUP_W]),
      .b     (i_vb[k*CLA_GROUP_W +: CLA_GROUP_W]),
      .cin   (grp_c[k]),
      .s     (sum[k*CLA_GROUP_W +: CLA_GROUP_W]),
      .grp_g (grp[k].g),
      .grp_p (grp[k].p)
    );
  end

  // Each group carry is the full lookahead expansion
  //   C(k) = G(k-1) | P(k-1)G(k-2) | ... | P(k-1)..P(0) c0
  // accumulated from the nearest group downward, so no carry depends on a
  // previously computed group carry.
  always_comb begin
    logic carry;
    logic prop;
    carry    = 1'b0;
    prop     = 1'b1;
    grp_c    = '0;
    grp_c[0] = i_c0;
    for (int unsigned k = 1; k <= NG; k++) begin
      carry = 1'b0;
      prop  = 1'b1;
      for (int unsigned j = 0; j < k; j++) begin
        carry = carry | (prop & grp[k-1-j].g);
        prop  = prop & grp[k-1-j].p;
      end
      grp_c[k] = carry | (prop & i_c0);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_v   <= '0;
      o_c32 <= 1'b0;
    end else begin
      o_v   <= sum;
      o_c32 <= grp_c[NG];
    end
  end

endmodule

// File: tb/tb_accumulator_32bit.sv
// tb_accumulator_32bit
//   Directed and random checks of the registered 32-bit CLA adder against a
//   plain-arithmetic reference of {carry, sum} = a + b + c0.
module tb_accumulator_32bit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] va;
  logic [31:0] vb;
  logic        c0;
  logic [31:0] v;
  logic        c32;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  accumulator_32bit #(.WIDTH(32)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .i_va  (va),
    .i_vb  (vb),
    .i_c0  (c0),
    .o_v   (v),
    .o_c32 (c32)
  );

  // Reference: what the outputs must hold after each edge.
  logic [31:0] m_v;
  logic        m_c;
  bit          m_valid = 1'b0;

  always @(posedge clk) begin
    logic [32:0] s;
    if (rst) s = 33'd0;
    else     s = {1'b0, va} + {1'b0, vb} + {32'd0, c0};
    m_v     <= s[31:0];
    m_c     <= s[32];
    m_valid <= 1'b1;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      n_checks++;
      if ({c32, v} !== {m_c, m_v}) begin
        n_fail++;
        $display("FAIL model_cmp t=%0t: got v=%h c=%b, expected v=%h c=%b",
                 $time, v, c32, m_v, m_c);
      end
    end
  end

  task automatic check_lit(input string name, input logic [31:0] ev,
                           input logic ec);
    n_checks++;
    if ({c32, v} !== {ec, ev}) begin
      n_fail++;
      $display("FAIL %s: got v=%h c=%b, expected v=%h c=%b",
               name, v, c32, ev, ec);
    end
  endtask

  task automatic step(input logic [31:0] a, input logic [31:0] b,
                      input logic c, input logic r);
    va  = a;
    vb  = b;
    c0  = c;
    rst = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [32:0] es;
    rst = 1'b1;
    va  = 32'h12345678;
    vb  = 32'h1;
    c0  = 1'b1;

    step(32'h12345678, 32'h1, 1'b1, 1'b1);
    check_lit("reset_edge1", 32'h0, 1'b0);
    step(32'h12345678, 32'h1, 1'b1, 1'b1);
    check_lit("reset_edge2", 32'h0, 1'b0);
    step(32'h12345678, 32'h1, 1'b1, 1'b0);
    check_lit("reset_release", 32'h1234567A, 1'b0);

    step(32'h0, 32'h0, 1'b0, 1'b0);
    check_lit("zero", 32'h0, 1'b0);
    step(32'h1, 32'h1, 1'b0, 1'b0);
    check_lit("one_one", 32'h2, 1'b0);
    step(32'h1, 32'h1, 1'b1, 1'b0);
    check_lit("one_one_cin", 32'h3, 1'b0);
    step(32'h5, 32'h6, 1'b1, 1'b0);
    check_lit("five_six_cin", 32'h0000000C, 1'b0);

    step(32'hFFFFFFFF, 32'h0, 1'b1, 1'b0);
    check_lit("full_prop", 32'h0, 1'b1);
    step(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0);
    check_lit("all_ones", 32'hFFFFFFFF, 1'b1);
    step(32'h0000000F, 32'h00000001, 1'b0, 1'b0);
    check_lit("group_cross", 32'h00000010, 1'b0);
    step(32'h80000000, 32'h80000000, 1'b0, 1'b0);
    check_lit("msb_wrap", 32'h0, 1'b1);
    step(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0);
    check_lit("msb_into", 32'h80000000, 1'b0);
    step(32'h0FFFFFFF, 32'h00000000, 1'b1, 1'b0);
    check_lit("prop_to_top_group", 32'h10000000, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      va  = $urandom;
      vb  = $urandom;
      c0  = 1'($urandom_range(0, 1));
      rst = (i == 500);
      es  = {1'b0, va} + {1'b0, vb} + {32'd0, c0};
      @(posedge clk);
      #1;
      if (i == 500) check_lit("midstream_reset", 32'h0, 1'b0);
      if (i == 501) check_lit("after_midstream_reset", es[31:0], es[32]);
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/accumulator_32bit.md
Name: accumulator_32bit

Overview:
- Registered 32-bit binary adder with carry-in and carry-out, computing o_v/o_c32 = i_va + i_vb + i_c0.
- Internally a two-level carry-lookahead adder: eight 4-bit CLA groups plus a group-level lookahead unit. There is no ripple chain across groups.
- Sits in the CPU datapath as the add core for ALU add/sub and PC/address arithmetic.
- One clock; reset is synchronous and active-high.

Parameters:
- WIDTH, 32, operand width. Must be a multiple of 4. Only 32 is verified.

Ports:
- i_clk  input  1  rising-edge clock.
- i_rst  input  1  synchronous, active-high reset.
- i_va  input  WIDTH  operand A, unsigned/two's-complement agnostic.
- i_vb  input  WIDTH  operand B.
- i_c0  input  1  carry into bit 0.
- o_v  output  WIDTH  registered sum, bits [WIDTH-1:0].
- o_c32  output  1  registered carry out of bit WIDTH-1.

Behaviour:
- Arithmetic: {c32, v} = i_va + i_vb + i_c0, exact (WIDTH+1)-bit result. No saturation; overflow wraps modulo 2^WIDTH, with the overflowed bit reported in o_c32.
- Signed overflow flag is not produced; the consumer derives it.
- Per-bit signals:
  - generate g = a & b
  - propagate p = a ^ b
  - sum = p ^ carry-in of that bit
- Group level (4 bits per group):
  - group generate G = g3 | p3 g2 | p3 p2 g1 | p3 p2 p1 g0
  - group propagate P = p3 p2 p1 p0
- Carry lookahead: group carries C4, C8, …, C32 are derived from G/P and i_c0 by lookahead equations. C32 drives o_c32.
- Timing: inputs are sampled on the rising edge of i_clk. o_v and o_c32 update on that same edge, so latency is 1 cycle and a new operation can be accepted every cycle.
- Reset: if i_rst = 1 at a rising edge, o_v <= 0 and o_c32 <= 0, regardless of the inputs.
  - Reset has priority over a simultaneous operation.
  - When reset is released, the first result appears one edge after i_rst is sampled low.
- Outputs hold their value while inputs are stable. There is no enable or handshake; every edge loads a fresh result.
- X/Z inputs are not supported; no special handling.

Decomposition:
- Shared package holds:
  - localparam CLA_GROUP_W = 4
  - number of groups = WIDTH/CLA_GROUP_W
- One sub-module, cla_4bit:
  - Inputs: a[3:0], b[3:0], cin.
  - Outputs: s[3:0], group generate G, group propagate P.
- The top level instantiates WIDTH/4 cla_4bit blocks in a generate loop and contains:
  - the group carry lookahead logic;
  - the output register with synchronous reset.

Test Plan:
- Reset: drive i_va=32'h12345678, i_vb=32'h1, i_c0=1, i_rst=1 for 2 edges -> o_v=32'h00000000, o_c32=0. Deassert i_rst -> next edge o_v=32'h1234567A, o_c32=0.
- Basic sums:
  - 0+0+0 -> o_v=0, c=0
  - 1+1+0 -> o_v=2, c=0
  - 1+1+1 -> o_v=3, c=0
  - 5+6+1 -> o_v=32'h0000000C, c=0
  - Each result appears one edge after the inputs are applied.
- Full carry propagation:
  - FFFFFFFF+0+1 -> o_v=0, c=1
  - FFFFFFFF+FFFFFFFF+1 -> o_v=FFFFFFFF, c=1
  - 0000000F+00000001+0 -> o_v=00000010, c=0 (crosses the first group boundary)
- MSB wrap: 80000000+80000000+0 -> o_v=0, c=1. 7FFFFFFF+00000001+0 -> o_v=80000000, c=0.
- Back-to-back pipeline: change operands every cycle over 1000 random vectors (including i_c0 random). Each cycle's output must equal the reference sum of the previous cycle's inputs, both the 32-bit value and the carry.
- Mid-stream reset: during the random stream, assert i_rst for one edge -> that edge's outputs are 0/0. The next edge shows the sum of the inputs present at that edge.
